// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: launches MULT/MULTU/DIV/DIVU, counts a fixed
// latency, commits HI/LO, and serves MTHI/MTLO/MFHI/MFLO plus the D-stage stall request.
module md_sequencer #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic        kill,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        d_is_md,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMthi  = 4'd5;
   localparam logic [3:0] OpMtlo  = 4'd6;
   localparam logic [3:0] OpMfhi  = 4'd7;
   localparam logic [3:0] OpMflo  = 4'd8;

   localparam int MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CntW   = $clog2(MaxLat + 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       shHi_q, shHi_d;
   logic [31:0]       shLo_q, shLo_d;

   logic              isLaunchOp;
   logic [63:0]       prodS;
   logic [63:0]       prodU;
   logic [31:0]       absA, absB;
   logic [31:0]       quoMag, remMag;
   logic [31:0]       quoS, remS;
   logic [31:0]       quoU, remU;

   assign isLaunchOp = start & ~kill & (md_op >= OpMult) & (md_op <= OpDivu);

   assign prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prodU = {32'b0, A} * {32'b0, B};

   // Signed divide works on magnitudes so truncation is toward zero and the
   // remainder takes the dividend's sign; the divide-by-zero result is never used.
   assign absA   = A[31] ? (~A + 32'd1) : A;
   assign absB   = B[31] ? (~B + 32'd1) : B;
   assign quoMag = (absB == 32'd0) ? 32'd0 : absA / absB;
   assign remMag = (absB == 32'd0) ? 32'd0 : absA % absB;
   assign quoS   = (A[31] ^ B[31]) ? (~quoMag + 32'd1) : quoMag;
   assign remS   = A[31] ? (~remMag + 32'd1) : remMag;
   assign quoU   = (B == 32'd0) ? 32'd0 : A / B;
   assign remU   = (B == 32'd0) ? 32'd0 : A % B;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         shHi_q  <= '0;
         shLo_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         shHi_q  <= shHi_d;
         shLo_q  <= shLo_d;
      end
   end

   // A zero divisor still occupies the unit; it shadows the current HI/LO so the commit is a no-op.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      shHi_d  = shHi_q;
      shLo_d  = shLo_q;
      case (state_q)
         IDLE: begin
            if (start && !kill) begin
               case (md_op)
                  OpMult: begin
                     {shHi_d, shLo_d} = prodS;
                     cnt_d            = CntW'(MULT_LAT);
                     state_d          = RUN;
                  end
                  OpMultu: begin
                     {shHi_d, shLo_d} = prodU;
                     cnt_d            = CntW'(MULT_LAT);
                     state_d          = RUN;
                  end
                  OpDiv: begin
                     shHi_d  = (B == 32'd0) ? hi_q : remS;
                     shLo_d  = (B == 32'd0) ? lo_q : quoS;
                     cnt_d   = CntW'(DIV_LAT);
                     state_d = RUN;
                  end
                  OpDivu: begin
                     shHi_d  = (B == 32'd0) ? hi_q : remU;
                     shLo_d  = (B == 32'd0) ? lo_q : quoU;
                     cnt_d   = CntW'(DIV_LAT);
                     state_d = RUN;
                  end
                  OpMthi:  hi_d = A;
                  OpMtlo:  lo_d = A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt_q == CntW'(1)) begin
               hi_d    = shHi_q;
               lo_d    = shLo_q;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q == RUN);
   assign stall_req = d_is_md & (busy | isLaunchOp);
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign md_out    = (md_op == OpMfhi) ? hi_q :
                      (md_op == OpMflo) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer: latency, results, stall, kill,
// divide-by-zero and mid-operation reset, all with hand-computed expectations.
module tb_md_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic        kill;
   logic [31:0] A;
   logic [31:0] B;
   logic        d_is_md;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_out;

   int compared   = 0;
   int mismatched = 0;

   md_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .md_op     (md_op),
      .kill      (kill),
      .A         (A),
      .B         (B),
      .d_is_md   (d_is_md),
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo),
      .md_out    (md_out)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic s, input logic [3:0] op, input logic k,
                                input logic [31:0] a, input logic [31:0] b, input logic dmd);
      start   = s;
      md_op   = op;
      kill    = k;
      A       = a;
      B       = b;
      d_is_md = dmd;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      step();
      step();
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_stall", {31'b0, stall_req}, 32'd0);
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);
      reset = 1'b1;

      // MULT -3 * 5
      applyStimulus(1'b1, 4'd1, 1'b0, 32'hFFFF_FFFD, 32'd5, 1'b0);
      step();
      applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("mult_busy", {31'b0, busy}, 32'd1);
         checkOutput("mult_lo_hold", lo, 32'd0);
         step();
      end
      checkOutput("mult_done", {31'b0, busy}, 32'd0);
      checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
      checkOutput("mult_lo", lo, 32'hFFFF_FFF1);

      // DIVU 7 / 2
      applyStimulus(1'b1, 4'd4, 1'b0, 32'd7, 32'd2, 1'b0);
      step();
      applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checkOutput("divu_busy", {31'b0, busy}, 32'd1);
         step();
      end
      checkOutput("divu_done", {31'b0, busy}, 32'd0);
      checkOutput("divu_lo", lo, 32'd3);
      checkOutput("divu_hi", hi, 32'd1);

      // DIV -7 / 2 with a dependent md instruction waiting in D
      applyStimulus(1'b1, 4'd3, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1);
      #1;
      checkOutput("div_launch_stall", {31'b0, stall_req}, 32'd1);
      step();
      applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         checkOutput("div_busy", {31'b0, busy}, 32'd1);
         checkOutput("div_stall", {31'b0, stall_req}, 32'd1);
         step();
      end
      checkOutput("div_stall_end", {31'b0, stall_req}, 32'd0);
      checkOutput("div_lo", lo, 32'hFFFF_FFFD);
      checkOutput("div_hi", hi, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 4'd8, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      checkOutput("mflo_out", md_out, 32'hFFFF_FFFD);
      checkOutput("mflo_no_stall", {31'b0, stall_req}, 32'd0);
      applyStimulus(1'b1, 4'd7, 1'b0, 32'd0, 32'd0, 1'b0);
      #1;
      checkOutput("mfhi_out", md_out, 32'hFFFF_FFFF);

      // Killed MULT has no effect
      applyStimulus(1'b1, 4'd1, 1'b1, 32'd4, 32'd4, 1'b0);
      step();
      checkOutput("kill_busy", {31'b0, busy}, 32'd0);
      checkOutput("kill_lo", lo, 32'hFFFF_FFFD);
      checkOutput("kill_hi", hi, 32'hFFFF_FFFF);

      // Reserved opcode behaves as NONE
      applyStimulus(1'b1, 4'd9, 1'b0, 32'd4, 32'd4, 1'b0);
      step();
      checkOutput("op9_busy", {31'b0, busy}, 32'd0);
      checkOutput("op9_lo", lo, 32'hFFFF_FFFD);

      // MTHI / MTLO
      applyStimulus(1'b1, 4'd5, 1'b0, 32'h0000_1234, 32'd0, 1'b0);
      step();
      checkOutput("mthi_hi", hi, 32'h0000_1234);
      checkOutput("mthi_busy", {31'b0, busy}, 32'd0);
      applyStimulus(1'b1, 4'd5, 1'b0, 32'd1, 32'd0, 1'b0);
      step();
      applyStimulus(1'b1, 4'd6, 1'b0, 32'd2, 32'd0, 1'b0);
      step();
      checkOutput("mtlo_lo", lo, 32'd2);
      checkOutput("mtlo_hi", hi, 32'd1);

      // DIV by zero; kill and MTHI during the run must be ignored
      applyStimulus(1'b1, 4'd3, 1'b0, 32'd9, 32'd0, 1'b0);
      step();
      applyStimulus(1'b0, 4'd0, 1'b1, 32'd0, 32'd0, 1'b0);
      step();
      applyStimulus(1'b1, 4'd5, 1'b0, 32'd99, 32'd0, 1'b0);
      step();
      checkOutput("dz_mthi_ignored", hi, 32'd1);
      applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checkOutput("dz_busy", {31'b0, busy}, 32'd1);
         step();
      end
      checkOutput("dz_done", {31'b0, busy}, 32'd0);
      checkOutput("dz_hi", hi, 32'd1);
      checkOutput("dz_lo", lo, 32'd2);

      // Reset during cycle 4 of a DIV aborts it
      applyStimulus(1'b1, 4'd3, 1'b0, 32'd100, 32'd7, 1'b0);
      step();
      applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      step();
      step();
      step();
      checkOutput("rst_mid_busy_before", {31'b0, busy}, 32'd1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_mid_hi", hi, 32'd0);
      checkOutput("rst_mid_lo", lo, 32'd0);
      for (int i = 0; i < 12; i++) begin
         step();
      end
      checkOutput("rst_no_late_commit", lo, 32'd0);

      // Fresh MULT 6 * 7 after the abort
      applyStimulus(1'b1, 4'd1, 1'b0, 32'd6, 32'd7, 1'b0);
      step();
      applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("mult2_busy", {31'b0, busy}, 32'd1);
         step();
      end
      checkOutput("mult2_lo", lo, 32'd42);
      checkOutput("mult2_hi", hi, 32'd0);

      // MULTU 0xFFFFFFFF * 2
      applyStimulus(1'b1, 4'd2, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
      step();
      applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
      end
      checkOutput("multu_hi", hi, 32'd1);
      checkOutput("multu_lo", lo, 32'hFFFF_FFFE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
